// File: rtl/add9_slice_sched.sv
// Two-requester, round-robin scheduled W-bit adder built on one shared SLICE_W-bit ripple slice.
// One slice per clock; the inter-slice carry is registered between passes.
module add9_slice_sched #(
  parameter int SLICE_W = 3,
  parameter int NSLICE  = 3,
  localparam int W      = SLICE_W * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic         busy
);

  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_ZERO = KW'(0);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [KW-1:0]     k_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      sum_r;
  logic              carry_r;
  logic              id_r;
  logic              last_grant_r;
  logic              res_valid_r;
  logic [W-1:0]      res_sum_r;
  logic              res_cout_r;
  logic              res_id_r;
  logic              busy_r;

  logic              grant_valid_s;
  logic              grant_id_s;
  logic [SLICE_W:0]  slice_s;
  logic [W-1:0]      sum_next_s;

  function automatic logic [SLICE_W:0] slice_add(
    input logic [SLICE_W-1:0] a,
    input logic [SLICE_W-1:0] b,
    input logic               cin
  );
    slice_add = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  endfunction

  // Round-robin grant: a tie goes to the requester not granted last time.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_grant_r;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready = (state_r == IDLE) && grant_valid_s && !grant_id_s;
  assign req1_ready = (state_r == IDLE) && grant_valid_s &&  grant_id_s;

  assign slice_s = slice_add(a_r[int'(k_r) * SLICE_W +: SLICE_W],
                             b_r[int'(k_r) * SLICE_W +: SLICE_W],
                             carry_r);

  // Merge the current slice result into the partial sum.
  always_comb begin
    sum_next_s = sum_r;
    sum_next_s[int'(k_r) * SLICE_W +: SLICE_W] = slice_s[SLICE_W-1:0];
  end

  // Sequencer: accept, run NSLICE slice passes, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      k_r          <= K_ZERO;
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      sum_r        <= {W{1'b0}};
      carry_r      <= 1'b0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
      res_valid_r  <= 1'b0;
      res_sum_r    <= {W{1'b0}};
      res_cout_r   <= 1'b0;
      res_id_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            a_r          <= grant_id_s ? req1_a   : req0_a;
            b_r          <= grant_id_s ? req1_b   : req0_b;
            carry_r      <= grant_id_s ? req1_cin : req0_cin;
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
            k_r          <= K_ZERO;
            busy_r       <= 1'b1;
            state_r      <= ADD;
          end
        end
        ADD: begin
          sum_r   <= sum_next_s;
          carry_r <= slice_s[SLICE_W];
          if (k_r == K_LAST) begin
            k_r         <= K_ZERO;
            res_sum_r   <= sum_next_s;
            res_cout_r  <= slice_s[SLICE_W];
            res_id_r    <= id_r;
            res_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_cout  = res_cout_r;
  assign res_id    = res_id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_add9_slice_sched.sv
// Directed self-checking bench for add9_slice_sched: handshake timing, arithmetic,
// round-robin ties, result backpressure and reset abort.
module tb_add9_slice_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [8:0] req0_a = 9'h000;
  logic [8:0] req0_b = 9'h000;
  logic       req0_cin = 1'b0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [8:0] req1_a = 9'h000;
  logic [8:0] req1_b = 9'h000;
  logic       req1_cin = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [8:0] res_sum;
  logic       res_cout;
  logic       res_id;
  logic       busy;

  int checks = 0;
  int failures = 0;

  add9_slice_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an operation on one requester and wait (bounded) for it to be accepted.
  task automatic issue(input logic id, input logic [8:0] a, input logic [8:0] b, input logic cin);
    logic rdy;
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy = id ? req1_ready : req0_ready;
      if (rdy) break;
      @(negedge clk);
    end
    check("grant", {15'd0, rdy}, 16'd1);
    if (rdy) begin
      @(posedge clk);
      #1;
      check("busy_after_accept", {15'd0, busy}, 16'd1);
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid, then check latency and result fields.
  task automatic expect_result(input logic id, input logic [8:0] sum, input logic cout);
    int lat;
    lat = 0;
    while (!res_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 16'(lat - 1), 16'd3);
    check("res_valid", {15'd0, res_valid}, 16'd1);
    check("res_id", {15'd0, res_id}, {15'd0, id});
    check("res_sum", {7'd0, res_sum}, {7'd0, sum});
    check("res_cout", {15'd0, res_cout}, {15'd0, cout});
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    check("idle_res_valid", {15'd0, res_valid}, 16'd0);
    check("idle_busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic v0, v1, seen;
    logic [8:0] bp_sum;
    logic bp_cout;
    int n, cyc, last_cyc;
    logic exp_id;

    // Reset state with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(1, 0));
      v1 = 1'($urandom_range(1, 0));
      req0_valid = v0; req1_valid = v1;
      req0_a = 9'($urandom); req1_a = 9'($urandom);
      res_ready = 1'($urandom_range(1, 0));
      #1;
      check("rst_res_valid", {15'd0, res_valid}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_req0_ready", {15'd0, req0_ready}, {15'd0, v0});
      check("rst_req1_ready", {15'd0, req1_ready}, {15'd0, v1 & ~v0});
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full carry ripple through all slices
    issue(1'b0, 9'h1FF, 9'h001, 1'b0);
    expect_result(1'b0, 9'h000, 1'b1);
    consume();

    // Carry-in feeding a mid-slice carry
    issue(1'b1, 9'h007, 9'h000, 1'b1);
    expect_result(1'b1, 9'h008, 1'b0);
    consume();

    // Tie arbitration from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 9'h001; req0_b = 9'h001; req0_cin = 1'b0;
    req1_a = 9'h002; req1_b = 9'h002; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    n = 0; cyc = 0; last_cyc = 0; exp_id = 1'b0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        check("tie_id", {15'd0, res_id}, {15'd0, exp_id});
        check("tie_sum", {7'd0, res_sum}, exp_id ? 16'h0004 : 16'h0002);
        if (n > 0) check("tie_interval", 16'(cyc - last_cyc), 16'd5);
        last_cyc = cyc;
        exp_id = ~exp_id;
        n++;
      end
    end
    check("tie_count", 16'(n), 16'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure: hold the result for 10 cycles while req1 waits
    res_ready = 1'b0;
    bp_sum = 9'h079; bp_cout = 1'b1;     // 0x1AB + 0x0CD + 1 = 0x279
    issue(1'b0, 9'h1AB, 9'h0CD, 1'b1);
    expect_result(1'b0, bp_sum, bp_cout);
    req1_a = 9'h010; req1_b = 9'h020; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {15'd0, res_valid}, 16'd1);
      check("bp_sum", {7'd0, res_sum}, {7'd0, bp_sum});
      check("bp_cout", {15'd0, res_cout}, {15'd0, bp_cout});
      check("bp_id", {15'd0, res_id}, 16'd0);
      check("bp_ready0", {15'd0, req0_ready}, 16'd0);
      check("bp_ready1", {15'd0, req1_ready}, 16'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {15'd0, res_valid}, 16'd0);
    check("bp_release_busy", {15'd0, busy}, 16'd0);
    check("bp_release_ready1", {15'd0, req1_ready}, 16'd1);
    req1_valid = 1'b0;
    @(negedge clk);

    // Reset one cycle after acceptance aborts the operation
    issue(1'b0, 9'h155, 9'h0AA, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res_valid", {15'd0, res_valid}, 16'd0);
    check("abort_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("abort_no_result", {15'd0, seen}, 16'd0);
    issue(1'b0, 9'h003, 9'h004, 1'b0);
    expect_result(1'b0, 9'h007, 1'b0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
